// File: rtl/accum_pkg.sv
// Shared types for the multi-operand accumulator.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

endpackage

// File: rtl/adder_nbit.sv
// Combinational ripple carry adder; overflow is the carry-out of the MSB.
module adder_nbit #(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    logic [NUM_BITS:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign overflow = carry[NUM_BITS];

endmodule

// File: rtl/accumulator_nbit.sv
// Sums NUM_SAMPLES unsigned operands through one ripple adder and presents
// the wrapped total plus a sticky carry-out flag over a valid/ready port.
module accumulator_nbit
    import accum_pkg::*;
#(
    parameter int NUM_BITS    = 4,
    parameter int NUM_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                in_ready,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [NUM_BITS-1:0] out_sum,
    output logic                out_overflow,
    output logic                busy
);

    localparam int            CW   = $clog2(NUM_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

    accum_state_t          state_q, state_d;
    logic [NUM_BITS-1:0]   acc_q, acc_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  sticky_q, sticky_d;

    logic [NUM_BITS-1:0]   add_sum;
    logic                  add_ovf;
    logic                  in_accept;

    adder_nbit #(.NUM_BITS(NUM_BITS)) u_adder (
        .a        (acc_q),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Decoded straight from the state flop so in_ready never depends on in_valid.
    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign out_sum      = out_valid ? acc_q : '0;
    assign out_overflow = out_valid & sticky_q;
    assign in_accept    = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        sticky_d = sticky_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACCUM;
                    acc_d    = '0;
                    count_d  = '0;
                    sticky_d = 1'b0;
                end
            end
            ACCUM: begin
                if (in_accept) begin
                    acc_d    = add_sum;
                    sticky_d = sticky_q | add_ovf;
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_accumulator_nbit.sv
// Directed bench for accumulator_nbit with a run-level reference model.
module tb_accumulator_nbit;

    localparam int NB = 4;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic [NB-1:0] in_data;
    logic          in_ready, out_valid, out_overflow, busy;
    logic [NB-1:0] out_sum;

    int checks = 0;
    int errors = 0;

    accumulator_nbit #(.NUM_BITS(NB), .NUM_SAMPLES(NS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: phase 0 idle, 1 collecting, 2 result; the true (unwrapped)
    // integer total gives the wrapped sum and overflow = total >= 2^NB.
    int m_phase, m_total, m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_total <= 0; m_cnt <= 0;
        end else if (m_phase == 0) begin
            if (start) begin m_phase <= 1; m_total <= 0; m_cnt <= 0; end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_total <= m_total + int'(in_data);
                m_cnt   <= m_cnt + 1;
                if (m_cnt + 1 == NS) m_phase <= 2;
            end
        end else begin
            if (out_ready) m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        chk("model_busy",      32'(busy),         32'(m_phase != 0));
        chk("model_in_ready",  32'(in_ready),     32'(m_phase == 1));
        chk("model_out_valid", 32'(out_valid),    32'(m_phase == 2));
        chk("model_out_sum",   32'(out_sum),      (m_phase == 2) ? 32'(m_total % (1 << NB)) : 32'd0);
        chk("model_out_ovf",   32'(out_overflow), 32'((m_phase == 2) && (m_total >= (1 << NB))));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [NB-1:0] v, input int gap, input logic st);
        in_valid = 1'b1;
        in_data  = v;
        start    = st;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        for (int g = 0; g < gap; g++) begin
            chk("gap_hold_ready", 32'(in_ready), 32'd1);
            tick();
        end
    endtask

    // Called right after the last accept: out_valid must already be up.
    task automatic expect_result(input string nm, input logic [NB-1:0] s, input logic o);
        chk({nm, "_latency"}, 32'(out_valid), 32'd1);
        chk({nm, "_sum"},     32'(out_sum),   32'(s));
        chk({nm, "_ovf"},     32'(out_overflow), 32'(o));
    endtask

    task automatic accept_result(input string nm);
        out_ready = 1'b1;
        tick();
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_out_sum",   32'(out_sum),   32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: 1+2+3+4 = A, no carry
        out_ready = 1'b1;
        begin_run();
        feed(4'h1, 0, 1'b0); feed(4'h2, 0, 1'b0); feed(4'h3, 0, 1'b0); feed(4'h4, 0, 1'b0);
        expect_result("t1", 4'hA, 1'b0);
        accept_result("t1");
        tick();

        // 2: 8+8 carries, later adds do not clear the flag
        begin_run();
        feed(4'h8, 0, 1'b0); feed(4'h8, 0, 1'b0); feed(4'h1, 0, 1'b0); feed(4'h0, 0, 1'b0);
        expect_result("t2", 4'h1, 1'b1);
        accept_result("t2");
        tick();

        // 3: gaps of 3 idle cycles between operands
        out_ready = 1'b0;
        begin_run();
        feed(4'hF, 3, 1'b0); feed(4'h1, 3, 1'b0); feed(4'h0, 3, 1'b0); feed(4'h0, 0, 1'b0);
        expect_result("t3", 4'h0, 1'b1);
        accept_result("t3");
        tick();

        // 4: consumer stalls 5 cycles; 7+7+7+0 = 21 -> 5 with carry
        out_ready = 1'b0;
        begin_run();
        feed(4'h7, 0, 1'b0); feed(4'h7, 0, 1'b0); feed(4'h7, 0, 1'b0); feed(4'h0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
            chk("t4_stall_sum",   32'(out_sum),   32'h5);
            chk("t4_stall_ovf",   32'(out_overflow), 32'd1);
            tick();
        end
        accept_result("t4");
        tick();

        // 5: reset after two accepts discards the partial run
        out_ready = 1'b0;
        begin_run();
        feed(4'h5, 0, 1'b0); feed(4'hE, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy",     32'(busy),      32'd0);
        chk("t5_rst_in_ready", 32'(in_ready),  32'd0);
        chk("t5_rst_valid",    32'(out_valid), 32'd0);
        chk("t5_rst_sum",      32'(out_sum),   32'd0);
        tick();
        rst = 1'b0;
        tick();
        begin_run();
        feed(4'h2, 0, 1'b0); feed(4'h2, 0, 1'b0); feed(4'h2, 0, 1'b0); feed(4'h2, 0, 1'b0);
        expect_result("t5", 4'h8, 1'b0);
        accept_result("t5");
        tick();

        // 6: start ignored in ACCUM and on the DONE accept edge; 3+4+5+6 = 18 -> 2
        out_ready = 1'b0;
        begin_run();
        feed(4'h3, 0, 1'b1); feed(4'h4, 0, 1'b1); feed(4'h5, 0, 1'b0); feed(4'h6, 0, 1'b0);
        expect_result("t6", 4'h2, 1'b1);
        start = 1'b1;
        accept_result("t6");
        start = 1'b0;
        chk("t6_no_restart_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t6_still_idle", 32'(busy), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
